// File: rtl/divclk_pwm_sequencer.sv
// rtl/divclk_pwm_sequencer.sv - div_clk edge ticker driving a double-buffered PWM
module divclk_pwm_sequencer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             div_clk,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic             tick,
    output logic             pwm_out,
    output logic             period_end,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [WIDTH-1:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0]       sh_period, sh_period_nxt, sh_duty, sh_duty_nxt;
    logic [WIDTH-1:0]       pend_period, pend_period_nxt, pend_duty, pend_duty_nxt;
    logic                   pend_valid, pend_valid_nxt;
    logic                   pwm_nxt, period_end_nxt;
    logic [WIDTH-1:0]       eff_period, eff_duty, cnt_inc;
    logic                   wrap;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk};
            prev_q <= sync_q[SYNC_STAGES-1];
            tick   <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // Values the shadow takes at a boundary: a coincident load bypasses pending.
    assign eff_period = load ? period : (pend_valid ? pend_period : sh_period);
    assign eff_duty   = load ? duty   : (pend_valid ? pend_duty   : sh_duty);
    assign cnt_inc    = cnt + WIDTH'(1);
    assign wrap       = tick && (cnt == sh_period - WIDTH'(1));

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pwm_nxt         = pwm_out;
        period_end_nxt  = 1'b0;
        sh_period_nxt   = sh_period;
        sh_duty_nxt     = sh_duty;
        pend_period_nxt = pend_period;
        pend_duty_nxt   = pend_duty;
        pend_valid_nxt  = pend_valid;
        case (state)
            IDLE: begin
                cnt_nxt        = '0;
                pwm_nxt        = 1'b0;
                sh_period_nxt  = eff_period;
                sh_duty_nxt    = eff_duty;
                pend_valid_nxt = 1'b0;
                if (tick && enable && (eff_period != '0)) begin
                    state_nxt = RUN;
                    pwm_nxt   = (eff_duty != '0);
                end
            end
            RUN, STOP: begin
                state_nxt = enable ? RUN : STOP;
                if (load) begin
                    pend_period_nxt = period;
                    pend_duty_nxt   = duty;
                    pend_valid_nxt  = 1'b1;
                end
                if (wrap) begin
                    period_end_nxt = 1'b1;
                    cnt_nxt        = '0;
                    sh_period_nxt  = eff_period;
                    sh_duty_nxt    = eff_duty;
                    pend_valid_nxt = 1'b0;
                    if (!enable || (eff_period == '0)) begin
                        state_nxt = IDLE;
                        pwm_nxt   = 1'b0;
                    end else begin
                        pwm_nxt = (eff_duty != '0);
                    end
                end else if (tick) begin
                    cnt_nxt = cnt_inc;
                    pwm_nxt = (cnt_inc < sh_duty);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sh_period   <= '0;
            sh_duty     <= '0;
            pend_period <= '0;
            pend_duty   <= '0;
            pend_valid  <= 1'b0;
            pwm_out     <= 1'b0;
            period_end  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sh_period   <= sh_period_nxt;
            sh_duty     <= sh_duty_nxt;
            pend_period <= pend_period_nxt;
            pend_duty   <= pend_duty_nxt;
            pend_valid  <= pend_valid_nxt;
            pwm_out     <= pwm_nxt;
            period_end  <= period_end_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
